// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file and its clear sequencer.
package reg_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W    = 64;
    localparam int DEF_DEPTH     = 32;
    localparam int DEF_DEBUG_IDX = 31;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear sequencer: walks every entry once, one per cycle, while blocking writes.
// clr_busy_o mirrors the FSM state (high exactly in CLEAR).
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              wr_ready_o,
    output logic              clr_en_o,
    output logic [ADDR_W-1:0] clr_idx_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clr_req while already sweeping is ignored; the sweep never restarts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_comb begin
        clr_busy_o = (state_q == CLEAR);
        wr_ready_o = (state_q == IDLE);
        clr_en_o   = (state_q == CLEAR);
        clr_idx_o  = cnt_q;
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async read ports, two sync write ports (port 1 wins).
// Optional write-to-read forwarding is enabled by defining REG_FILE_MP_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int DEBUG_IDX = DEF_DEBUG_IDX
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_RD*addr_w(DEPTH)-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]           rd_data,
    input  logic [1:0]                         wr_enable,
    input  logic [2*addr_w(DEPTH)-1:0]         wr_addr,
    input  logic [2*DATA_W-1:0]                wr_data,
    output logic                               wr_ready,
    input  logic                               clr_req,
    output logic                               clr_busy,
    output logic [DATA_W-1:0]                  debug_output
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam logic [ADDR_W-1:0] DBG_ADDR = ADDR_W'(DEBUG_IDX);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              clr_en;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] wa [2];
    logic [DATA_W-1:0] wd [2];

    reg_file_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_req_i  (clr_req),
        .clr_busy_o (clr_busy),
        .wr_ready_o (wr_ready),
        .clr_en_o   (clr_en),
        .clr_idx_o  (clr_idx)
    );

    assign wa[0] = wr_addr[0 +: ADDR_W];
    assign wa[1] = wr_addr[ADDR_W +: ADDR_W];
    assign wd[0] = wr_data[0 +: DATA_W];
    assign wd[1] = wr_data[DATA_W +: DATA_W];

    // Port 1 is applied last so it overrides port 0 on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (clr_en) begin
            regs_d[clr_idx] = '0;
        end
        for (int j = 0; j < 2; j++) begin
            if (wr_enable[j] && wr_ready && !(ZERO_REG != 0 && wa[j] == '0)) begin
                regs_d[wa[j]] = wd[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rv = regs_q[ra];
`ifdef REG_FILE_MP_BYPASS_EN
            if (wr_ready) begin
                if (wr_enable[0] && wa[0] == ra) rv = wd[0];
                if (wr_enable[1] && wa[1] == ra) rv = wd[1];
            end
`endif
            if (ZERO_REG != 0 && ra == '0) rv = '0;
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
    end

    always_comb begin
        debug_output = regs_q[DBG_ADDR];
        if (ZERO_REG != 0 && DBG_ADDR == '0) debug_output = '0;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp against an array model of the register file.
// Define REG_FILE_MP_BYPASS_EN for both RTL and bench to check forwarding.
module tb_reg_file_mp;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 32;
    localparam int NUM_RD    = 2;
    localparam int ADDR_W    = 5;
    localparam int DEBUG_IDX = 31;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [1:0]                 wr_enable;
    logic [2*ADDR_W-1:0]        wr_addr;
    logic [2*DATA_W-1:0]        wr_data;
    logic                       wr_ready;
    logic                       clr_req;
    logic                       clr_busy;
    logic [DATA_W-1:0]          debug_output;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1), .DEBUG_IDX(DEBUG_IDX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_enable    (wr_enable),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .clr_req      (clr_req),
        .clr_busy     (clr_busy),
        .debug_output (debug_output)
    );

    logic [DATA_W-1:0] model [DEPTH];
    int                sweep_left = 0;
    int                sweep_idx  = 0;
    int                total      = 0;
    int                bad        = 0;
    logic [DATA_W-1:0] exp_q [$];

    task automatic drive_idle();
        rst       = 1'b0;
        clr_req   = 1'b0;
        wr_enable = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr   = '0;
    endtask

    task automatic drive_write(input int port, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_enable[port]                  = 1'b1;
        wr_addr[port*ADDR_W +: ADDR_W]   = a;
        wr_data[port*DATA_W +: DATA_W]   = d;
    endtask

    task automatic set_rd(input int port, input logic [ADDR_W-1:0] a);
        rd_addr[port*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] get_rd(input int port);
        return rd_data[port*DATA_W +: DATA_W];
    endfunction

    // Expected read value from the model plus the currently driven write ports.
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (a == 0) return '0;
        v = model[a];
`ifdef REG_FILE_MP_BYPASS_EN
        if (sweep_left == 0) begin
            if (wr_enable[0] && wr_addr[0 +: ADDR_W] == a) v = wr_data[0 +: DATA_W];
            if (wr_enable[1] && wr_addr[ADDR_W +: ADDR_W] == a) v = wr_data[DATA_W +: DATA_W];
        end
`endif
        return v;
    endfunction

    // One clock: update the model from the driven inputs at the edge, then return to idle inputs.
    task automatic tick();
        logic [ADDR_W-1:0] a;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
            sweep_left = 0;
            sweep_idx  = 0;
        end else if (sweep_left > 0) begin
            model[sweep_idx] = '0;
            sweep_idx++;
            sweep_left--;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (wr_enable[j]) begin
                    a = wr_addr[j*ADDR_W +: ADDR_W];
                    if (a != 0) model[a] = wr_data[j*DATA_W +: DATA_W];
                end
            end
            if (clr_req) begin
                sweep_left = DEPTH;
                sweep_idx  = 0;
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 10; c++) begin
            drive_write(0, ADDR_W'($urandom_range(1, DEPTH-1)), {$urandom, $urandom});
            drive_write(1, ADDR_W'($urandom_range(1, DEPTH-1)), {$urandom, $urandom});
            tick();
        end
        rst = 1'b1;
        tick();
        #1;
        total++;
        if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        total++;
        if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
        total++;
        if (debug_output !== '0) begin bad++; $display("FAIL reset_debug got=%h exp=0", debug_output); end
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(0, ADDR_W'(i));
            set_rd(1, ADDR_W'(DEPTH-1-i));
            #1;
            total++;
            if (get_rd(0) !== '0 || get_rd(1) !== '0) begin
                bad++;
                $display("FAIL reset_read addr=%0d got0=%h got1=%h exp=0", i, get_rd(0), get_rd(1));
            end
        end
        tick();
    endtask

    task automatic test_collision();
        drive_write(0, 5, 64'hAAAA);
        drive_write(1, 5, 64'h5555);
        tick();
        set_rd(0, 5);
        set_rd(1, 5);
        #1;
        total++;
        if (get_rd(0) !== 64'h5555) begin bad++; $display("FAIL collision_p0 got=%h exp=%h", get_rd(0), 64'h5555); end
        total++;
        if (get_rd(1) !== 64'h5555) begin bad++; $display("FAIL collision_p1 got=%h exp=%h", get_rd(1), 64'h5555); end
        tick();
    endtask

    task automatic test_zero_reg();
        drive_write(0, 0, 64'hDEAD);
        set_rd(0, 0);
        #1;
        total++;
        if (get_rd(0) !== '0) begin bad++; $display("FAIL zero_same_cycle got=%h exp=0", get_rd(0)); end
        tick();
        set_rd(1, 0);
        #1;
        total++;
        if (get_rd(1) !== '0) begin bad++; $display("FAIL zero_after got=%h exp=0", get_rd(1)); end
        drive_write(1, 31, 64'hBEEF);
        tick();
        #1;
        total++;
        if (debug_output !== 64'hBEEF) begin bad++; $display("FAIL debug_beef got=%h exp=%h", debug_output, 64'hBEEF); end
    endtask

    task automatic test_clear_sweep();
        int                k;
        logic [ADDR_W-1:0] a0, a1;
        for (int c = 0; c < DEPTH/2; c++) begin
            drive_write(0, ADDR_W'(2*c), DATA_W'(2*c + 1));
            drive_write(1, ADDR_W'(2*c + 1), DATA_W'(2*c + 2));
            tick();
        end
        clr_req = 1'b1;
        drive_write(0, 9, 64'h99);
        tick();
        k = 0;
        while (clr_busy === 1'b1 && k < 100) begin
            a0 = (k == 4) ? ADDR_W'(7) : ADDR_W'(k % DEPTH);
            a1 = (k == 0) ? ADDR_W'(0) : ADDR_W'((k - 1) % DEPTH);
            set_rd(0, a0);
            set_rd(1, a1);
            if (k == 3) drive_write(0, 7, 64'h7777);
            if (k == 15) clr_req = 1'b1;
            #1;
            total++;
            if (wr_ready !== 1'b0) begin bad++; $display("FAIL sweep_wr_ready k=%0d got=%b exp=0", k, wr_ready); end
            total++;
            if (get_rd(0) !== exp_read(a0) || get_rd(1) !== exp_read(a1)) begin
                bad++;
                $display("FAIL sweep_read k=%0d got0=%h exp0=%h got1=%h exp1=%h",
                         k, get_rd(0), exp_read(a0), get_rd(1), exp_read(a1));
            end
            tick();
            k++;
        end
        total++;
        if (k !== DEPTH) begin bad++; $display("FAIL sweep_busy_cycles got=%0d exp=%0d", k, DEPTH); end
        #1;
        total++;
        if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL sweep_done got ready=%b busy=%b exp ready=1 busy=0", wr_ready, clr_busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(0, ADDR_W'(i));
            #1;
            total++;
            if (get_rd(0) !== '0) begin bad++; $display("FAIL sweep_zero addr=%0d got=%h exp=0", i, get_rd(0)); end
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        for (int c = 0; c < DEPTH/2; c++) begin
            drive_write(0, ADDR_W'(2*c), {$urandom, $urandom});
            drive_write(1, ADDR_W'(2*c + 1), {$urandom, $urandom});
            tick();
        end
        clr_req = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) tick();
        rst = 1'b1;
        tick();
        #1;
        total++;
        if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_state got busy=%b ready=%b exp busy=0 ready=1", clr_busy, wr_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(1, ADDR_W'(i));
            #1;
            total++;
            if (get_rd(1) !== '0) begin bad++; $display("FAIL midrst_zero addr=%0d got=%h exp=0", i, get_rd(1)); end
        end
        drive_write(1, 12, 64'hC0DE);
        tick();
        set_rd(0, 12);
        #1;
        total++;
        if (get_rd(0) !== 64'hC0DE) begin bad++; $display("FAIL midrst_write got=%h exp=%h", get_rd(0), 64'hC0DE); end
        tick();
    endtask

    task automatic test_bypass();
        logic [DATA_W-1:0] want;
        drive_write(0, 3, 64'h1111);
        tick();
        drive_write(0, 3, 64'h1234);
        set_rd(0, 3);
        #1;
`ifdef REG_FILE_MP_BYPASS_EN
        want = 64'h1234;
`else
        want = 64'h1111;
`endif
        total++;
        if (get_rd(0) !== want) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", get_rd(0), want); end
        tick();
        set_rd(0, 3);
        #1;
        total++;
        if (get_rd(0) !== 64'h1234) begin bad++; $display("FAIL bypass_next got=%h exp=%h", get_rd(0), 64'h1234); end
        tick();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a0, a1, r0, r1;
        logic [DATA_W-1:0] got;
        for (int c = 0; c < 300; c++) begin
            a0 = ADDR_W'($urandom_range(0, DEPTH-1));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : ADDR_W'($urandom_range(0, DEPTH-1));
            if ($urandom_range(0, 1) == 1) drive_write(0, a0, {$urandom, $urandom});
            if ($urandom_range(0, 1) == 1) drive_write(1, a1, {$urandom, $urandom});
            r0 = ($urandom_range(0, 2) == 0) ? a0 : ADDR_W'($urandom_range(0, DEPTH-1));
            r1 = ($urandom_range(0, 2) == 0) ? a1 : ADDR_W'($urandom_range(0, DEPTH-1));
            set_rd(0, r0);
            set_rd(1, r1);
            exp_q.push_back(exp_read(r0));
            exp_q.push_back(exp_read(r1));
            exp_q.push_back(model[DEBUG_IDX]);
            #1;
            for (int p = 0; p < 3; p++) begin
                got = (p == 2) ? debug_output : get_rd(p);
                total++;
                if (got !== exp_q[0]) begin
                    bad++;
                    $display("FAIL random c=%0d port=%0d got=%h exp=%h", c, p, got, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        tick();
        test_reset();
        test_collision();
        test_zero_reg();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port successor to the single-cycle core's 32x64 register file.
- Supports N asynchronous read ports and two synchronous write ports with fixed priority.
- Optional hardwired-zero register.
- Hardware clear sequencer that sweeps all entries to zero, one per cycle, without a full reset.
- Sits in the decode/writeback path; feeds the ALU operands and the debug output pins.

Parameters:
- DATA_W, 64, width of each register in bits
- DEPTH, 32, number of registers; power of two, >= 4
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1: register 0 reads as zero and ignores writes; 0: register 0 is an ordinary register
- DEBUG_IDX, 31, index mirrored on debug_output; must be < DEPTH

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k occupies slice [k*ADDR_W +: ADDR_W]; ADDR_W = $clog2(DEPTH)
- rd_data  out  NUM_RD*DATA_W  packed read data, same slicing as rd_addr
- wr_enable  in  2  per-write-port enables
- wr_addr  in  2*ADDR_W  packed write addresses
- wr_data  in  2*DATA_W  packed write data
- wr_ready  out  1  high when writes are accepted (sequencer idle)
- clr_req  in  1  single-cycle pulse that starts a clear sweep
- clr_busy  out  1  high while a sweep is in progress
- debug_output  out  DATA_W  combinational copy of register DEBUG_IDX

Behaviour:
- Reset: when rst is high at a clock edge:
  - all registers become 0
  - sequencer goes to IDLE and sweep counter becomes 0
  - clr_busy=0, wr_ready=1
  - debug_output and rd_data therefore read 0 after the edge.
- Reads: combinational, zero latency; rd_data[k] = reg[rd_addr[k]].
  - With ZERO_REG=1, address 0 always returns 0.
- Writes: take effect at the clock edge; visible on reads in the following cycle. Port j writes when wr_enable[j] && wr_ready.
  - Both ports enabled with the same address: port 1 wins; port 0's write is dropped.
  - ZERO_REG=1 and address 0: the write is discarded silently.
- Sequencer states:
  - IDLE: wr_ready=1, clr_busy=0. clr_req=1 moves to CLEAR with cnt=0. Writes presented in that same cycle are still accepted.
  - CLEAR: wr_ready=0, clr_busy=1. Each cycle reg[cnt] <= 0 and cnt increments. When cnt==DEPTH-1, that entry is cleared and the sequencer returns to IDLE. Total busy time is exactly DEPTH cycles.
  - In CLEAR, wr_enable is ignored (not queued). The writer must hold off while wr_ready=0.
  - clr_req during CLEAR is ignored; the sweep does not restart.
  - Reads during CLEAR return current contents: entries already swept read 0, the rest read old values.
- rst asserted mid-sweep: the sweep aborts and all entries clear on that edge. The sequencer is in IDLE on the next cycle.
- Counter width is ADDR_W; no wrap beyond DEPTH-1 occurs.

Optional Feature:
- Macro: REG_FILE_MP_BYPASS_EN
- Defined: write-to-read forwarding. If a read address matches an accepted write (wr_enable && wr_ready) in the same cycle, rd_data returns that wr_data combinationally.
  - Port 1 has priority over port 0.
  - The forwarded value respects ZERO_REG (address 0 still reads 0).
  - Forwarding is suppressed in CLEAR.
- Undefined: no forwarding; a read always returns the pre-edge register contents.

Decomposition:
- Shared package reg_file_pkg holds:
  - typedef clr_state_t (IDLE, CLEAR)
  - default constants for DATA_W, DEPTH, DEBUG_IDX
  - helper function for the address width.
- One sub-module, reg_file_clr_seq: contains the FSM and sweep counter, and outputs clr_busy, wr_ready, clr_en and clr_idx.
- The storage array and read muxing stay in reg_file_mp.

Test Plan:
- Reset: drive rst=1 for one edge after random writes -> every read address returns 0, debug_output=0, wr_ready=1, clr_busy=0.
- Write collision: wr_enable=2'b11, both addresses 5, data0=0xAAAA, data1=0x5555 -> the next cycle rd_addr=5 reads 0x5555.
- Zero register (ZERO_REG=1): write 0xDEAD to address 0 -> reads at address 0 return 0. Write 0xBEEF to address 31 -> debug_output=0xBEEF the next cycle.
- Clear sweep (DEPTH=32): fill all entries with their index plus 1, then pulse clr_req.
  - clr_busy is high for exactly 32 cycles.
  - A write to address 7 during the sweep is dropped.
  - After the sweep, all entries read 0 and wr_ready returns to 1.
- Reset mid-sweep: pulse rst at sweep cycle 10 -> all entries are 0 immediately and clr_busy=0 the next cycle. A write is accepted the cycle after.
- Bypass (macro defined): write 0x1234 to address 3 while reading address 3 in the same cycle -> rd_data=0x1234 in that cycle. With the macro undefined, the old value is returned.
